// File: rtl/iq_bit_slicer.sv
// IQ bit slicer: hard-decides averaged I/Q symbols, hunts for a sync byte, then
// assembles a fixed-length payload into bytes with a weak-bit quality count.
module iq_bit_slicer #(
    parameter int         NBITS       = 32,
    parameter int         THRESH      = 1024,
    parameter logic [7:0] SYNC        = 8'h7E,
    parameter int         FRAME_BYTES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBITS-1:0] avg_i,
    input  logic [NBITS-1:0] avg_q,
    input  logic             avg_valid,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             frame_done,
    output logic [7:0]       weak_count,
    output logic             overflow,
    output logic             in_frame
);

    typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

    localparam logic [NBITS:0] THRESH_W  = (NBITS + 1)'(THRESH);
    localparam logic [7:0]     LAST_BYTE = 8'(FRAME_BYTES - 1);

    // One extra bit so the most negative input maps to +2^(NBITS-1) exactly.
    function automatic logic [NBITS:0] magnitude(input logic [NBITS-1:0] v);
        logic [NBITS:0] ext;
        ext = {v[NBITS-1], v};
        if (v[NBITS-1]) begin
            magnitude = ~ext + {{NBITS{1'b0}}, 1'b1};
        end else begin
            magnitude = ext;
        end
    endfunction

    state_t         state_r, state_s;
    logic [7:0]     hist_r, hist_s;
    logic [7:0]     shreg_r, shreg_s;
    logic [2:0]     bit_cnt_r, bit_cnt_s;
    logic [7:0]     byte_cnt_r, byte_cnt_s;
    logic [7:0]     weak_work_r, weak_work_s;
    logic [7:0]     weak_count_s;
    logic           done_s;
    logic           byte_done_s;
    logic [NBITS:0] abs_i_s, abs_q_s;
    logic           bit_s, weak_s;
    logic           load_s, drop_s, valid_s;

    assign abs_i_s = magnitude(avg_i);
    assign abs_q_s = magnitude(avg_q);
    assign bit_s   = ~avg_i[NBITS-1];
    assign weak_s  = (abs_i_s < THRESH_W) || (abs_i_s <= abs_q_s);

    // Next-state: sync hunt, payload assembly, weak counting and frame end.
    always_comb begin
        state_s      = state_r;
        hist_s       = hist_r;
        shreg_s      = shreg_r;
        bit_cnt_s    = bit_cnt_r;
        byte_cnt_s   = byte_cnt_r;
        weak_work_s  = weak_work_r;
        weak_count_s = weak_count;
        done_s       = 1'b0;
        byte_done_s  = 1'b0;
        case (state_r)
            HUNT: begin
                if (avg_valid) begin
                    hist_s = {hist_r[6:0], bit_s};
                    if (hist_s == SYNC) begin
                        state_s     = DATA;
                        bit_cnt_s   = 3'd0;
                        byte_cnt_s  = 8'd0;
                        weak_work_s = 8'd0;
                    end else begin
                        state_s = HUNT;
                    end
                end else begin
                    state_s = HUNT;
                end
            end
            DATA: begin
                if (avg_valid) begin
                    shreg_s = {shreg_r[6:0], bit_s};
                    if (weak_s && (weak_work_r != 8'hFF)) begin
                        weak_work_s = weak_work_r + 8'd1;
                    end else begin
                        weak_work_s = weak_work_r;
                    end
                    if (bit_cnt_r == 3'd7) begin
                        byte_done_s = 1'b1;
                        bit_cnt_s   = 3'd0;
                        byte_cnt_s  = byte_cnt_r + 8'd1;
                        // Dropped bytes still advance byte_cnt, so the frame length is fixed.
                        if (byte_cnt_r == LAST_BYTE) begin
                            done_s       = 1'b1;
                            weak_count_s = weak_work_s;
                            hist_s       = 8'd0;
                            state_s      = HUNT;
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s = HUNT;
            end
        endcase
    end

    // Output handshake: a completed byte loads only into a free or draining slot.
    always_comb begin
        load_s = byte_done_s && (!byte_valid || byte_ready);
        drop_s = byte_done_s && byte_valid && !byte_ready;
        if (load_s) begin
            valid_s = 1'b1;
        end else if (byte_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = byte_valid;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= HUNT;
            hist_r      <= 8'd0;
            shreg_r     <= 8'd0;
            bit_cnt_r   <= 3'd0;
            byte_cnt_r  <= 8'd0;
            weak_work_r <= 8'd0;
            byte_out    <= 8'd0;
            byte_valid  <= 1'b0;
            frame_done  <= 1'b0;
            weak_count  <= 8'd0;
            overflow    <= 1'b0;
            in_frame    <= 1'b0;
        end else begin
            state_r     <= state_s;
            hist_r      <= hist_s;
            shreg_r     <= shreg_s;
            bit_cnt_r   <= bit_cnt_s;
            byte_cnt_r  <= byte_cnt_s;
            weak_work_r <= weak_work_s;
            byte_valid  <= valid_s;
            frame_done  <= done_s;
            weak_count  <= weak_count_s;
            overflow    <= overflow | drop_s;
            in_frame    <= (state_s == DATA);
            if (load_s) begin
                byte_out <= shreg_s;
            end
        end
    end

endmodule

// File: tb/tb_iq_bit_slicer.sv
// Randomized bench for iq_bit_slicer against a bit-stream level reference model.
module tb_iq_bit_slicer;

    localparam int FB = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] avg_i, avg_q;
    logic               avg_valid, byte_ready;
    logic [7:0]         byte_out;
    logic               byte_valid, frame_done, overflow, in_frame;
    logic [7:0]         weak_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame position counted as total payload bits received.
    int m_hunt = 1, m_hist = 0, m_cur = 0, m_nbits = 0, m_wwork = 0;
    int m_bo = 0, m_bv = 0, m_fd = 0, m_wc = 0, m_ovf = 0;

    always #5 clk = ~clk;

    iq_bit_slicer #(.NBITS(32), .THRESH(1024), .SYNC(8'h7E), .FRAME_BYTES(FB)) dut (
        .clk(clk), .rst(rst), .avg_i(avg_i), .avg_q(avg_q), .avg_valid(avg_valid),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .frame_done(frame_done), .weak_count(weak_count), .overflow(overflow),
        .in_frame(in_frame)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input longint i, input longint q, input bit rdy);
        longint ai, aq;
        bit     b, wk, comp;
        int     byteval;
        comp = 1'b0;
        byteval = 0;
        if (r) begin
            m_hunt = 1; m_hist = 0; m_cur = 0; m_nbits = 0; m_wwork = 0;
            m_bo = 0; m_bv = 0; m_fd = 0; m_wc = 0; m_ovf = 0;
        end else begin
            m_fd = 0;
            if (v) begin
                b  = (i >= 0);
                ai = (i < 0) ? -i : i;
                aq = (q < 0) ? -q : q;
                wk = (ai < 1024) || (ai <= aq);
                if (m_hunt != 0) begin
                    m_hist = ((m_hist << 1) | int'(b)) & 255;
                    if (m_hist == 8'h7E) begin
                        m_hunt = 0; m_nbits = 0; m_wwork = 0;
                    end
                end else begin
                    m_cur = ((m_cur << 1) | int'(b)) & 255;
                    if (wk && m_wwork < 255) m_wwork++;
                    m_nbits++;
                    if (m_nbits % 8 == 0) begin
                        comp = 1'b1;
                        byteval = m_cur;
                        if (m_nbits == FB * 8) begin
                            m_fd = 1; m_wc = m_wwork; m_hist = 0; m_hunt = 1;
                        end
                    end
                end
            end
            if (comp) begin
                if (m_bv == 0 || rdy) begin
                    m_bo = byteval; m_bv = 1;
                end else begin
                    m_ovf = 1;
                end
            end else if (rdy) begin
                m_bv = 0;
            end
        end
    endtask

    task automatic check_all();
        check_val("byte_out", byte_out, m_bo);
        check_val("byte_valid", byte_valid, m_bv);
        check_val("frame_done", frame_done, m_fd);
        check_val("weak_count", weak_count, m_wc);
        check_val("overflow", overflow, m_ovf);
        check_val("in_frame", in_frame, (m_hunt == 0) ? 1 : 0);
    endtask

    task automatic step(input bit r, input bit v, input logic signed [31:0] i,
                        input logic signed [31:0] q, input bit rdy);
        rst = r; avg_valid = v; avg_i = i; avg_q = q; byte_ready = rdy;
        @(posedge clk);
        model_edge(r, v, longint'(i), longint'(q), rdy);
        #1;
        check_all();
    endtask

    function automatic bit pick_rdy(input int rdy);
        if (rdy == 2) return ($urandom_range(0, 3) != 0);
        return (rdy != 0);
    endfunction

    // mode 0 strong, 1 small |I|, 2 |Q| >= |I|, 3 extreme (-2^31 or 0)
    task automatic sym_for(input bit b, input int mode, output logic signed [31:0] i,
                           output logic signed [31:0] q);
        int m, qq;
        case (mode)
            0: begin m = $urandom_range(1024, 1000000); qq = $urandom_range(0, m - 1); end
            1: begin m = $urandom_range(1, 1023); qq = $urandom_range(0, 2000); end
            2: begin m = $urandom_range(1024, 100000); qq = m + $urandom_range(0, 10); end
            default: begin m = 0; qq = $urandom_range(0, 3); end
        endcase
        if ($urandom_range(0, 1) != 0) qq = -qq;
        if (mode == 3) i = b ? 32'sd0 : 32'sh80000000;
        else i = b ? m : -m;
        q = qq;
    endtask

    task automatic send_bit(input bit b, input int rdy, input int mode);
        logic signed [31:0] i, q;
        repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, 32'sd0, 32'sd0, pick_rdy(rdy));
        sym_for(b, mode, i, q);
        step(1'b0, 1'b1, i, q, pick_rdy(rdy));
    endtask

    task automatic send_byte(input int val, input int rdy);
        for (int k = 7; k >= 0; k--) send_bit(val[k], rdy, 0);
    endtask

    task automatic send_rand_bytes(input int n, input int rdy);
        for (int k = 0; k < n; k++) send_byte($urandom_range(0, 255), rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 32'sd5000, 32'sd0, 1'b1);
        step(1'b1, 1'b0, 32'sd0, 32'sd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; avg_valid = 1'b0; avg_i = 32'sd0; avg_q = 32'sd0; byte_ready = 1'b0;
        do_reset();
        check_val("reset_in_frame", in_frame, 1'b0);

        // Sync then data with free-flowing sink
        send_byte(8'h7E, 1);
        check_val("lock_in_frame", in_frame, 1'b1);
        send_byte(8'hA5, 1);
        check_val("first_byte", byte_out, 8'hA5);
        check_val("first_valid", byte_valid, 1'b1);
        send_byte(8'h3C, 1);
        send_rand_bytes(FB - 2, 1);
        check_val("frame_done_pulse", frame_done, 1'b1);
        check_val("in_frame_after", in_frame, 1'b0);
        step(1'b0, 1'b0, 32'sd0, 32'sd0, 1'b1);

        // Weak bits: three small-|I| and one |I|<=|Q|
        send_byte(8'h7E, 1);
        step(1'b0, 1'b1, 32'sd100, 32'sd0, 1'b1);
        step(1'b0, 1'b1, -32'sd100, 32'sd0, 1'b1);
        step(1'b0, 1'b1, 32'sd100, 32'sd0, 1'b1);
        step(1'b0, 1'b1, 32'sd2000, -32'sd2000, 1'b1);
        for (int k = 0; k < 4; k++) send_bit(1'b0, 1, 0);
        check_val("weak_byte", byte_out, 8'hB0);
        send_rand_bytes(FB - 1, 1);
        check_val("weak_count4", weak_count, 8'd4);

        // Extreme inputs
        send_byte(8'h7E, 1);
        step(1'b0, 1'b1, 32'sh80000000, 32'sd0, 1'b1);
        step(1'b0, 1'b1, 32'sd0, 32'sd0, 1'b1);
        for (int k = 0; k < 6; k++) send_bit(1'b1, 1, 0);
        check_val("extreme_byte", byte_out, 8'h7F);
        send_rand_bytes(FB - 1, 1);
        check_val("weak_count1", weak_count, 8'd1);

        // Back-pressure: first byte held, second dropped
        send_byte(8'h7E, 1);
        send_byte(8'h5A, 0);
        send_byte(8'hC3, 0);
        check_val("bp_held", byte_out, 8'h5A);
        check_val("bp_overflow", overflow, 1'b1);
        send_rand_bytes(FB - 2, 1);
        check_val("bp_sticky", overflow, 1'b1);
        do_reset();
        check_val("bp_cleared", overflow, 1'b0);

        // Reset mid-frame, then a clean frame
        send_byte(8'h7E, 1);
        send_rand_bytes(5, 1);
        do_reset();
        check_val("mid_rst_in_frame", in_frame, 1'b0);
        check_val("mid_rst_valid", byte_valid, 1'b0);
        send_byte(8'h7E, 2);
        send_rand_bytes(FB, 1);
        check_val("restart_done", frame_done, 1'b1);

        // Sync hunt: prefix with no run of ones, then 0x3F 0x7E
        do_reset();
        for (int k = 0; k < 6; k++) begin
            send_bit($urandom_range(0, 1), 1, 0);
            send_bit(1'b0, 1, 0);
        end
        send_byte(8'h3F, 1);
        check_val("no_lock_3f", in_frame, 1'b0);
        send_bit(1'b0, 1, 0);
        check_val("lock_overlap", in_frame, 1'b1);
        for (int k = 0; k < 6; k++) send_bit(1'b1, 1, 0);
        send_bit(1'b0, 1, 0);
        send_rand_bytes(FB - 1, 1);
        send_bit(1'b1, 1, 0);
        check_val("overlap_done", frame_done, 1'b1);

        // Randomized traffic: mixed symbol classes and random sink readiness
        do_reset();
        for (int f = 0; f < 6; f++) begin
            for (int k = 7; k >= 0; k--) send_bit(((8'h7E >> k) & 1) != 0, 2, $urandom_range(0, 3));
            for (int k = 0; k < 150; k++) send_bit($urandom_range(0, 1), 2, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
